// File: rtl/digital_calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | digital_calc_pkg : shared types, segment codes and BCD helper            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package digital_calc_pkg;

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_OP  = 3'd1,
    S_DIV = 3'd2,
    S_RES = 3'd3,
    S_ERR = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  // BCD conversion covers the largest supported display (8 digits, 27 bits).
  localparam int c_BCD_DIGITS = 8;
  localparam int c_BCD_BIN_W  = 27;

  // Active-low {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] c_SEG_BLANK = 8'hFF;
  localparam logic [7:0] c_SEG_E     = 8'h86;
  localparam logic [7:0] c_SEG_MINUS = 8'hBF;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return c_SEG_BLANK;
    endcase
  endfunction

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  // Double dabble; callers keep only the low 4*DIGITS bits they display.
  function automatic logic [4*c_BCD_DIGITS-1:0] bin2bcd(input logic [c_BCD_BIN_W-1:0] bin);
    logic [4*c_BCD_DIGITS-1:0] bcd;
    bcd = '0;
    for (int i = c_BCD_BIN_W - 1; i >= 0; i--) begin
      for (int d = 0; d < c_BCD_DIGITS; d++) begin
        if (bcd[4*d +: 4] > 4'd4) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[4*c_BCD_DIGITS-2:0], bin[i]};
    end
    return bcd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digital_calc_param_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_seq_divider : W-bit restoring divider, one quotient bit per cycle   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module calc_seq_divider #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quot
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvs;
  logic          r_busy;
  logic [W:0]    w_shift;
  logic [W:0]    w_diff;
  logic [W-1:0]  w_rem_nxt;
  logic [W-1:0]  w_quo_nxt;

  // Bit W of the difference doubles as the borrow: set means "does not fit".
  always_comb begin
    w_shift   = {r_rem, r_quo[W-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_rem_nxt = w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
    w_quo_nxt = {r_quo[W-2:0], ~w_diff[W]};
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CW'(W - 1));
  assign o_quot = w_quo_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dvs  <= i_divisor;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/digital_calc_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | digital_calc_param : keypad calculator core with 7-segment scan output   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module digital_calc_param
  import digital_calc_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int W           = 14,
  parameter int REFRESH_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_digit,
  input  logic [3:0]        key_val,
  input  logic              key_add,
  input  logic              key_sub,
  input  logic              key_mul,
  input  logic              key_div,
  input  logic              key_eq,
  input  logic              key_clr,
  output logic [DIGITS-1:0] digit_sel,
  output logic [7:0]        seg,
  output logic [W-1:0]      result,
  output logic              neg,
  output logic              err,
  output logic              busy
);

  localparam int c_K_DIG = 0, c_K_ADD = 1, c_K_SUB = 2, c_K_MUL = 3;
  localparam int c_K_DIV = 4, c_K_EQ  = 5, c_K_CLR = 6;
  localparam int IW = $clog2(DIGITS);
  localparam int SW = $clog2(REFRESH_DIV);
  localparam logic [2*W-1:0] c_MAX = (2*W)'(pow10(DIGITS) - 32'd1);
  localparam logic [W-1:0]   c_LIM = W'(pow10(DIGITS - 1));
  localparam logic [W-1:0]   c_TEN = W'(10);

  logic [6:0]  w_keys, r_key_q, r_ev;
  logic [3:0]  r_val;
  state_e      r_state, w_state_nxt;
  op_e         r_op, w_op_nxt, w_op_sel;
  logic [W-1:0] r_a, r_b, r_res, w_a_nxt, w_b_nxt, w_res_nxt;
  logic [W-1:0] w_val_ext, w_a_dig, w_b_dig;
  logic        r_bent, r_neg, w_bent_nxt, w_neg_nxt, w_op_ev;
  logic [2*W-1:0] w_arith;
  logic        w_arith_neg, w_div_start, w_div_done;
  logic [W-1:0] w_div_quot;

  assign w_keys = {key_clr, key_eq, key_div, key_mul, key_sub, key_add, key_digit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_q <= '0;
      r_ev    <= '0;
      r_val   <= '0;
    end else begin
      r_key_q <= w_keys;
      r_ev    <= w_keys & ~r_key_q;
      r_val   <= key_val;
    end
  end

  assign w_val_ext = {{(W-4){1'b0}}, r_val};
  assign w_a_dig   = r_a * c_TEN + w_val_ext;
  assign w_b_dig   = r_b * c_TEN + w_val_ext;
  assign w_op_ev   = r_ev[c_K_DIV] | r_ev[c_K_MUL] | r_ev[c_K_SUB] | r_ev[c_K_ADD];

  always_comb begin
    w_op_sel = OP_ADD;
    if      (r_ev[c_K_DIV]) w_op_sel = OP_DIV;
    else if (r_ev[c_K_MUL]) w_op_sel = OP_MUL;
    else if (r_ev[c_K_SUB]) w_op_sel = OP_SUB;
  end

  always_comb begin
    w_arith     = '0;
    w_arith_neg = 1'b0;
    case (r_op)
      OP_ADD: w_arith = (2*W)'(r_a) + (2*W)'(r_b);
      OP_SUB: begin
        w_arith_neg = (r_b > r_a);
        w_arith     = w_arith_neg ? (2*W)'(r_b - r_a) : (2*W)'(r_a - r_b);
      end
      OP_MUL: w_arith = (2*W)'(r_a) * (2*W)'(r_b);
      default: w_arith = '0;
    endcase
  end

  // Event priority falls out of the if/else order: clr, eq, operators, digit.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_bent_nxt  = r_bent;
    w_res_nxt   = r_res;
    w_neg_nxt   = r_neg;
    w_div_start = 1'b0;
    if (r_ev[c_K_CLR]) begin
      w_state_nxt = S_A;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_op_nxt    = OP_ADD;
      w_bent_nxt  = 1'b0;
      w_res_nxt   = '0;
      w_neg_nxt   = 1'b0;
    end else if (r_state == S_DIV) begin
      if (w_div_done) begin
        w_res_nxt   = w_div_quot;
        w_neg_nxt   = 1'b0;
        w_state_nxt = S_RES;
      end
    end else if (r_state != S_ERR) begin
      if (r_ev[c_K_EQ]) begin
        if (r_state == S_OP) begin
          if (r_op == OP_DIV) begin
            if (r_b == '0) begin
              w_state_nxt = S_ERR;
            end else begin
              w_div_start = 1'b1;
              w_state_nxt = S_DIV;
            end
          end else if (w_arith > c_MAX) begin
            w_state_nxt = S_ERR;
          end else begin
            w_res_nxt   = w_arith[W-1:0];
            w_neg_nxt   = w_arith_neg;
            w_state_nxt = S_RES;
          end
        end
      end else if (w_op_ev) begin
        w_op_nxt = w_op_sel;
        if (r_state != S_OP) begin
          w_b_nxt     = '0;
          w_bent_nxt  = 1'b0;
          w_state_nxt = S_OP;
          if (r_state == S_RES) begin
            w_a_nxt   = r_res;
            w_neg_nxt = 1'b0;
          end
        end
      end else if (r_ev[c_K_DIG] && (r_val <= 4'd9)) begin
        case (r_state)
          S_A:  if (r_a < c_LIM) w_a_nxt = w_a_dig;
          S_OP: if (r_b < c_LIM) begin
            w_b_nxt    = w_b_dig;
            w_bent_nxt = 1'b1;
          end
          S_RES: begin
            w_a_nxt     = w_val_ext;
            w_state_nxt = S_A;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_bent  <= 1'b0;
      r_res   <= '0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_bent  <= w_bent_nxt;
      r_res   <= w_res_nxt;
      r_neg   <= w_neg_nxt;
    end
  end

  calc_seq_divider #(.W(W)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_abort    (r_ev[c_K_CLR]),
    .i_dividend (r_a),
    .i_divisor  (r_b),
    .o_busy     (busy),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot)
  );

  assign result = r_res;
  assign neg    = r_neg;
  assign err    = (r_state == S_ERR);

  logic [W-1:0]           w_disp_val;
  logic                   w_disp_neg;
  logic [c_BCD_BIN_W-1:0] w_bin;
  logic [4*DIGITS-1:0]    w_bcd;
  logic [3:0]             w_ndig, w_idx4, w_digit;
  logic [7:0]             w_seg;
  logic [IW-1:0]          r_idx;
  logic [SW-1:0]          r_scan_cnt;

  always_comb begin
    w_disp_val = r_a;
    if (r_state == S_RES) w_disp_val = r_res;
    else if ((r_state == S_OP || r_state == S_DIV) && r_bent) w_disp_val = r_b;
    w_disp_neg = (r_state == S_RES) && r_neg;
    w_bin      = '0;
    w_bin[W-1:0] = w_disp_val;
    w_bcd      = (4*DIGITS)'(bin2bcd(w_bin));
    w_ndig     = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_bcd[4*i +: 4] != 4'd0) w_ndig = 4'(i + 1);
    end
  end

  // Sign sits just left of the number; with no room left it moves to the top dp.
  always_comb begin
    w_idx4  = 4'(r_idx);
    w_digit = w_bcd[{r_idx, 2'b00} +: 4];
    w_seg   = c_SEG_BLANK;
    if (r_state == S_ERR) begin
      if (r_idx == '0) w_seg = c_SEG_E;
    end else begin
      if (w_idx4 < w_ndig) w_seg = seg_digit(w_digit);
      else if (w_disp_neg && (w_idx4 == w_ndig)) w_seg = c_SEG_MINUS;
      if (w_disp_neg && (w_ndig == 4'(DIGITS)) && (w_idx4 == 4'(DIGITS - 1))) w_seg[7] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      digit_sel  <= '1;
      seg        <= c_SEG_BLANK;
    end else if (r_scan_cnt == SW'(REFRESH_DIV - 1)) begin
      r_scan_cnt <= '0;
      digit_sel  <= ~(DIGITS'(1) << r_idx);
      seg        <= w_seg;
      r_idx      <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digital_calc_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_digital_calc_param : vector table, corner sequences, random vs model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_digital_calc_param;

  localparam int DIGITS = 4, W = 14, REFRESH_DIV = 4;
  localparam int K_DIG = 0, K_ADD = 1, K_SUB = 2, K_MUL = 3, K_DIV = 4, K_EQ = 5, K_CLR = 6;
  localparam int MAXV = 10**DIGITS - 1;
  localparam int LIM  = 10**(DIGITS - 1);

  logic clk = 1'b0, rst_n = 1'b0;
  logic key_digit = 0, key_add = 0, key_sub = 0, key_mul = 0, key_div = 0, key_eq = 0, key_clr = 0;
  logic [3:0] key_val = '0;
  logic [DIGITS-1:0] digit_sel;
  logic [7:0] seg;
  logic [W-1:0] result;
  logic neg, err, busy;

  always #5 clk = ~clk;

  digital_calc_param #(.DIGITS(DIGITS), .W(W), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .key_digit(key_digit), .key_val(key_val),
    .key_add(key_add), .key_sub(key_sub), .key_mul(key_mul), .key_div(key_div),
    .key_eq(key_eq), .key_clr(key_clr), .digit_sel(digit_sel), .seg(seg),
    .result(result), .neg(neg), .err(err), .busy(busy)
  );

  int n_vec = 0, n_bad = 0;

  // Reference model: 0 = entering A, 1 = entering B, 2 = result, 3 = error
  int m_st, m_a, m_b, m_op, m_res;
  bit m_bent, m_neg;

  function automatic void model_reset();
    m_st = 0; m_a = 0; m_b = 0; m_op = K_ADD; m_res = 0; m_bent = 0; m_neg = 0;
  endfunction

  function automatic void model_press(int k, int v);
    int r;
    bit n;
    if (k == K_CLR) begin
      model_reset();
      return;
    end
    if (m_st == 3) return;
    if (k == K_EQ) begin
      if (m_st != 1) return;
      n = 0;
      case (m_op)
        K_ADD: r = m_a + m_b;
        K_SUB: begin r = (m_a >= m_b) ? m_a - m_b : m_b - m_a; n = (m_b > m_a); end
        K_MUL: r = m_a * m_b;
        default: r = (m_b == 0) ? MAXV + 1 : m_a / m_b;
      endcase
      if (r > MAXV) m_st = 3;
      else begin m_res = r; m_neg = n; m_st = 2; end
    end else if (k == K_DIG) begin
      if (v > 9) return;
      if (m_st == 0 && m_a < LIM) m_a = m_a * 10 + v;
      else if (m_st == 1 && m_b < LIM) begin m_b = m_b * 10 + v; m_bent = 1; end
      else if (m_st == 2) begin m_a = v; m_st = 0; end
    end else begin
      if (m_st == 2) begin m_a = m_res; m_neg = 0; end
      if (m_st != 1) begin m_b = 0; m_bent = 0; m_st = 1; end
      m_op = k;
    end
  endfunction

  function automatic logic [7:0] dig_code(int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0; 4: return 8'h99;
      5: return 8'h92; 6: return 8'h82; 7: return 8'hF8; 8: return 8'h80; default: return 8'h90;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(int i);
    int val, nd, t;
    bit sn;
    logic [7:0] s;
    if (m_st == 3) return (i == 0) ? 8'h86 : 8'hFF;
    val = (m_st == 2) ? m_res : ((m_st == 1 && m_bent) ? m_b : m_a);
    sn  = (m_st == 2) && m_neg;
    nd = 0; t = val;
    while (t > 0) begin nd++; t = t / 10; end
    if (nd == 0) nd = 1;
    if (i < nd) s = dig_code((val / (10**i)) % 10);
    else if (sn && i == nd) s = 8'hBF;
    else s = 8'hFF;
    if (sn && nd == DIGITS && i == DIGITS - 1) s[7] = 1'b0;
    return s;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic settle();
    int c;
    c = 0;
    while (busy && c < 40) begin @(negedge clk); c++; end
    if (busy) chk("busy timeout", 1, 0);
  endtask

  task automatic press(int k, int v);
    @(negedge clk);
    key_val = 4'(v);
    case (k)
      K_DIG: key_digit = 1; K_ADD: key_add = 1; K_SUB: key_sub = 1; K_MUL: key_mul = 1;
      K_DIV: key_div = 1; K_EQ: key_eq = 1; default: key_clr = 1;
    endcase
    @(negedge clk);
    {key_digit, key_add, key_sub, key_mul, key_div, key_eq, key_clr} = '0;
    repeat (3) @(negedge clk);
    settle();
    model_press(k, v);
  endtask

  task automatic check_outputs(string tag);
    chk({tag, " result"}, int'(result), m_res);
    chk({tag, " neg"}, int'(neg), int'(m_neg));
    chk({tag, " err"}, int'(err), int'(m_st == 3));
    chk({tag, " busy"}, int'(busy), 0);
  endtask

  task automatic check_display(string tag);
    logic [7:0] cap [DIGITS];
    bit seen [DIGITS];
    for (int i = 0; i < DIGITS; i++) begin seen[i] = 0; cap[i] = '0; end
    repeat (DIGITS*REFRESH_DIV + 2) @(negedge clk);
    for (int c = 0; c < 2*DIGITS*REFRESH_DIV; c++) begin
      @(negedge clk);
      for (int i = 0; i < DIGITS; i++)
        if (digit_sel == ~(DIGITS'(1) << i)) begin cap[i] = seg; seen[i] = 1; end
    end
    for (int i = 0; i < DIGITS; i++)
      chk($sformatf("%s seg[%0d]", tag, i), seen[i] ? int'(cap[i]) : -1, int'(exp_seg(i)));
  endtask

  typedef struct {
    int k; int v; bit chk; int res; bit ng; bit er; bit disp;
  } vec_t;
  vec_t tbl [24];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, rq, last_res, k, v;
    bit fell, seen_busy;

    tbl[0]  = '{K_DIG, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{K_DIG, 2, 0, 0, 0, 0, 0};
    tbl[2]  = '{K_DIG, 3, 0, 0, 0, 0, 1};
    tbl[3]  = '{K_ADD, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{K_DIG, 4, 0, 0, 0, 0, 0};
    tbl[5]  = '{K_DIG, 5, 0, 0, 0, 0, 1};
    tbl[6]  = '{K_EQ,  0, 1, 168, 0, 0, 1};
    for (int i = 7; i < 12; i++) tbl[i] = '{K_DIG, 9, 0, 0, 0, 0, (i == 11)};
    tbl[12] = '{K_MUL, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{K_DIG, 2, 0, 0, 0, 0, 0};
    tbl[14] = '{K_EQ,  0, 1, -1, 0, 1, 1};
    tbl[15] = '{K_CLR, 0, 1, 0, 0, 0, 1};
    tbl[16] = '{K_DIG, 3, 0, 0, 0, 0, 0};
    tbl[17] = '{K_SUB, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{K_DIG, 1, 0, 0, 0, 0, 0};
    tbl[19] = '{K_DIG, 0, 0, 0, 0, 0, 0};
    tbl[20] = '{K_EQ,  0, 1, 7, 1, 0, 1};
    tbl[21] = '{K_ADD, 0, 0, 0, 0, 0, 0};
    tbl[22] = '{K_DIG, 2, 0, 0, 0, 0, 0};
    tbl[23] = '{K_EQ,  0, 1, 9, 0, 0, 1};

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset digit_sel", int'(digit_sel), 15);
    chk("reset seg", int'(seg), 255);
    check_outputs("reset");
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 50 && cnt == 0; c++) begin
      @(posedge clk); #1;
      if (digit_sel != '1) cnt = c + 1;
    end
    chk("first lit edge", cnt, REFRESH_DIV);
    chk("first lit digit_sel", int'(digit_sel), 14);

    for (int i = 0; i < 24; i++) begin
      press(tbl[i].k, tbl[i].v);
      if (tbl[i].chk) begin
        if (tbl[i].res >= 0) chk($sformatf("vec%0d result", i), int'(result), tbl[i].res);
        chk($sformatf("vec%0d neg", i), int'(neg), int'(tbl[i].ng));
        chk($sformatf("vec%0d err", i), int'(err), int'(tbl[i].er));
      end
      if (tbl[i].disp) check_display($sformatf("vec%0d", i));
    end

    // Divider timing: 100 / 7
    press(K_DIG, 1); press(K_DIG, 0); press(K_DIG, 0); press(K_DIV, 0); press(K_DIG, 7);
    @(negedge clk); key_eq = 1;
    @(negedge clk); key_eq = 0;
    cnt = 0; fell = 0; rq = -1; last_res = -1;
    for (int c = 0; c < 40 && !fell; c++) begin
      @(negedge clk);
      if (busy) begin cnt++; last_res = int'(result); end
      else if (cnt > 0) begin fell = 1; rq = int'(result); end
    end
    chk("div busy cycles", cnt, W);
    chk("div result held while busy", last_res, 9);
    chk("div result at busy fall", rq, 14);
    model_press(K_EQ, 0);
    check_outputs("div");

    // Divide by zero never starts the divider
    press(K_DIG, 1); press(K_DIG, 0); press(K_DIG, 0); press(K_DIV, 0);
    @(negedge clk); key_eq = 1;
    @(negedge clk); key_eq = 0;
    seen_busy = 0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (busy) seen_busy = 1; end
    chk("div0 busy seen", int'(seen_busy), 0);
    model_press(K_EQ, 0);
    check_outputs("div0");
    check_display("div0");
    press(K_CLR, 0);
    check_outputs("clr after div0");

    // Simultaneous add+sub: sub wins
    press(K_DIG, 5);
    @(negedge clk); key_add = 1; key_sub = 1;
    @(negedge clk); key_add = 0; key_sub = 0;
    repeat (3) @(negedge clk);
    model_press(K_SUB, 0);
    press(K_DIG, 5); press(K_EQ, 0);
    chk("add+sub result", int'(result), 0);
    check_outputs("add+sub");
    press(K_DIG, 4); press(K_DIG, 12);
    check_display("keyval12");

    // clr during divide
    press(K_CLR, 0);
    press(K_DIG, 1); press(K_DIG, 0); press(K_DIG, 0); press(K_DIV, 0); press(K_DIG, 7);
    @(negedge clk); key_eq = 1;
    @(negedge clk); key_eq = 0;
    cnt = 0;
    while (!busy && cnt < 10) begin @(negedge clk); cnt++; end
    chk("abort busy started", int'(busy), 1);
    repeat (3) @(negedge clk);
    key_clr = 1;
    @(negedge clk); key_clr = 0;
    @(negedge clk);
    chk("abort busy", int'(busy), 0);
    model_press(K_CLR, 0);
    check_outputs("abort");
    check_display("abort");

    // Random keys against the model
    for (int n = 0; n < 120; n++) begin
      k = $urandom_range(0, 19);
      v = $urandom_range(0, 11);
      if (k == 10) k = K_ADD;
      else if (k == 11) k = K_SUB;
      else if (k == 12) k = K_MUL;
      else if (k == 13) k = K_DIV;
      else if (k >= 14 && k <= 16) k = K_EQ;
      else if (k == 17) k = K_CLR;
      else k = K_DIG;
      press(k, v);
      check_outputs($sformatf("rnd%0d", n));
      if (n % 15 == 0) check_display($sformatf("rnd%0d", n));
    end

    // Asynchronous reset mid-scan
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async rst digit_sel", int'(digit_sel), 15);
    chk("async rst seg", int'(seg), 255);
    check_outputs("async rst");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digital_calc_param.md
# digital_calc_param

Parametrised keypad calculator core: accepts decimal digit and operator key presses, performs add, subtract, multiply and divide on unsigned DIGITS-digit operands, and drives a time-multiplexed seven-segment display. Successor to the fixed 4-digit calculator. Adds:
- configurable digit count;
- a sequential divider;
- a sign indicator;
- explicit error state for overflow and divide-by-zero;
- result chaining.

Sits between the debounced board buttons and the seven-segment display pins.

## Interface
Parameters:
- DIGITS, 4, number of displayed decimal digits (2..8)
- W, 14, operand/result magnitude width; must satisfy 2^W > 10^DIGITS - 1
- REFRESH_DIV, 1024, clock cycles each digit is lit during display scan

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- key_digit  in  1  digit key level; value taken from key_val
- key_val  in  4  digit value 0..9; values 10..15 ignored
- key_add, key_sub, key_mul, key_div  in  1 each  operator key levels
- key_eq  in  1  equals key level
- key_clr  in  1  clear key level
- digit_sel  out  DIGITS  one-hot active-low digit enable, bit 0 = least significant digit
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- result  out  W  magnitude of last computed result
- neg  out  1  result is negative
- err  out  1  error state
- busy  out  1  divide in progress

## Operation
- All key inputs are synchronous levels held for ≥1 cycle. Each key has a one-register rising-edge detector; one event per press.
- Simultaneous events are resolved by priority: clr > eq > div > mul > sub > add > digit. Lower-priority events in the same cycle are dropped.
- States: S_A (entering A), S_OP (operator held, entering B), S_DIV (dividing), S_RES (showing result), S_ERR.
- Digit entry: operand = operand*10 + key_val.
  - Ignored when key_val > 9.
  - Ignored when the operand already has DIGITS significant digits.
  - Leading zero does not count as a digit.
- S_A + op → store op, S_OP, B = 0.
- S_OP + op → replace op only.
- S_OP + digit → B entry.
- S_OP + eq → compute, then:
  - add/sub/mul: S_RES.
  - div: S_DIV.
- S_RES + op → A = result (sign cleared if neg; the chained value uses the magnitude), S_OP.
- S_RES + digit → A = digit, S_A.
- S_A + eq → no effect.
- Arithmetic:
  - add A+B.
  - sub: |A−B| with neg = (B>A).
  - mul: 2W-bit product.
  - div: quotient, remainder discarded.
- Result > 10^DIGITS−1 → S_ERR. Divide by B=0 → S_ERR without entering S_DIV.
- S_ERR: err=1, display shows "E" on digit 0 and blanks elsewhere. Only clr leaves S_ERR.
- clr from any state, including S_DIV (aborts the divider): A=B=0, result=0, neg=0, err=0 → S_A.
- Display value:
  - operand being entered in S_A/S_OP (B once its first digit arrives, else A);
  - result in S_RES.
- Display formatting:
  - leading zeros blanked; value 0 shows a single "0";
  - neg lights segment g on the lowest blank digit (left of the number), or dp of the top digit if all digits are used.
- Keys other than clr are ignored while busy=1.

## Timing
- Reset: state S_A; A, B, result = 0; neg=0, err=0, busy=0; digit_sel = all ones (none lit), seg = 8'hFF, scan counter 0.
- Key event: processed on the clock edge after the first high sample. Operand/display value updates 2 cycles after the key input rises.
- add/sub/mul: result, neg and err valid 1 cycle after the eq event is processed.
- div: restoring, 1 quotient bit per cycle. busy rises in the cycle after the eq event and stays high exactly W cycles. result updates and busy falls in the same cycle.
- Display scan: digit index advances every REFRESH_DIV cycles, wrapping DIGITS−1 → 0. digit_sel and seg are registered and change together.
- First lit digit: digit 0, REFRESH_DIV cycles after reset release.

## Structure
- Shared package digital_calc_pkg holds:
  - state enum;
  - op enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV);
  - 7-segment encodings for 0..9, "E", "−", blank;
  - binary-to-BCD function (double dabble) parametrised on DIGITS.
- Sub-module calc_seq_divider (W-bit restoring divider, start/busy/done, synchronous abort input) instantiated once.
- Scan counter and segment encoding live in the top level.

## Test plan
- Reset, then press 1,2,3, add, 4,5, eq → result=168, neg=0, display "168".
- Press 9 five times (DIGITS=4) → A=9999; fifth press ignored. Then mul, 2, eq → err=1, display "E"; clr → err=0, display "0".
- 3, sub, 1,0, eq → result=7, neg=1, minus lit on digit 1. Then add, 2, eq → result=9, neg=0 (chained magnitude 7+2).
- 1,0,0, div, 7, eq → busy high for exactly W=14 cycles, then result=14. Repeat with divisor 0 → err=1 with busy never asserted.
- key_add and key_sub rise in the same cycle after A=5; then 5, eq → sub wins, result=0. key_val=12 digit press → no change.
- clr asserted mid-divide (busy=1) → busy=0 next cycle, state S_A, result=0. Async rst_n low mid-scan → all outputs at reset values immediately.
